// File: rtl/instr_mem_responder_if.sv
// Fetch/preload bus between the CPU and the instruction memory responder.
// master: CPU side (drives PC, READ, loads); slave: memory side (INSTRUCTION, BUSYWAIT).
interface instr_mem_responder_if #(
    parameter int MEM_DEPTH = 1024
);
    localparam int AW = $clog2(MEM_DEPTH);

    logic [31:0]   PC;
    logic          READ;
    logic          LOADEN;
    logic [AW-1:0] LOADADDR;
    logic [7:0]    LOADDATA;
    logic [31:0]   INSTRUCTION;
    logic          BUSYWAIT;

    modport master (
        output PC, READ, LOADEN, LOADADDR, LOADDATA,
        input  INSTRUCTION, BUSYWAIT
    );

    modport slave (
        input  PC, READ, LOADEN, LOADADDR, LOADDATA,
        output INSTRUCTION, BUSYWAIT
    );
endinterface

// File: rtl/instr_mem_responder.sv
// Byte-wide instruction store with multi-cycle word fetch and byte preload.
// Ports: CLK, RESET (sync, active-high), bus (slave: PC/READ/LOAD* in, INSTRUCTION/BUSYWAIT out).
// Option: define IMEM_LINEBUF_EN to add a single 16-byte line buffer for same-edge hits.
module instr_mem_responder #(
    parameter int MEM_DEPTH = 1024,
    parameter int LATENCY   = 4
) (
    input logic                  CLK,
    input logic                  RESET,
    instr_mem_responder_if.slave bus
);
    localparam int AW = $clog2(MEM_DEPTH);

    typedef enum logic {IDLE, WAIT} state_t;

    logic [7:0] mem [MEM_DEPTH];

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-3:0] widx_q, widx_d;
    logic          busy_q, busy_d;
    logic [31:0]   instr_q, instr_d;
    logic          fill;
    logic [31:0]   miss_word;

    // PC bits outside the wrapped word index are ignored by design.
    logic unused_pc;
    assign unused_pc = ^{bus.PC[31:AW], bus.PC[1:0]};

    assign miss_word = {mem[{widx_q, 2'd3}], mem[{widx_q, 2'd2}],
                        mem[{widx_q, 2'd1}], mem[{widx_q, 2'd0}]};

`ifdef IMEM_LINEBUF_EN
    logic [7:0]    line_q [16];
    logic [AW-5:0] tag_q, tag_d;
    logic          valid_q, valid_d;
    logic          hit;
    logic [31:0]   hit_word;

    assign hit = valid_q && (tag_q == bus.PC[AW-1:4]);
    assign hit_word = {line_q[{bus.PC[3:2], 2'd3}], line_q[{bus.PC[3:2], 2'd2}],
                       line_q[{bus.PC[3:2], 2'd1}], line_q[{bus.PC[3:2], 2'd0}]};

    // A load into the block about to be (or already) buffered wins over the fill.
    always_comb begin
        tag_d   = fill ? widx_q[AW-3:2] : tag_q;
        valid_d = fill | valid_q;
        if (bus.LOADEN && (bus.LOADADDR[AW-1:4] == tag_d))
            valid_d = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            if (fill) begin
                for (int i = 0; i < 16; i++)
                    line_q[i] <= mem[{widx_q[AW-3:2], 4'(i)}];
            end
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        widx_d  = widx_q;
        busy_d  = busy_q;
        instr_d = instr_q;
        fill    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.READ) begin
`ifdef IMEM_LINEBUF_EN
                    if (hit) begin
                        instr_d = hit_word;
                    end else begin
                        widx_d  = bus.PC[AW-1:2];
                        cnt_d   = 4'(LATENCY - 1);
                        busy_d  = 1'b1;
                        state_d = WAIT;
                    end
`else
                    widx_d  = bus.PC[AW-1:2];
                    cnt_d   = 4'(LATENCY - 1);
                    busy_d  = 1'b1;
                    state_d = WAIT;
`endif
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    instr_d = miss_word;
                    busy_d  = 1'b0;
                    fill    = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            widx_q  <= '0;
            busy_q  <= 1'b0;
            instr_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            widx_q  <= widx_d;
            busy_q  <= busy_d;
            instr_q <= instr_d;
        end
    end

    // Store is never cleared; reset only blocks the load on its edge.
    always_ff @(posedge CLK) begin
        if (!RESET && bus.LOADEN)
            mem[bus.LOADADDR] <= bus.LOADDATA;
    end

    assign bus.INSTRUCTION = instr_q;
    assign bus.BUSYWAIT    = busy_q;
endmodule

// File: tb/tb_instr_mem_responder.sv
// Directed-vector bench for instr_mem_responder (default and IMEM_LINEBUF_EN builds).
// Ports: drives CLK, RESET and the fetch/preload bus; checks INSTRUCTION and BUSYWAIT.
module tb_instr_mem_responder;
    logic CLK = 1'b0;
    logic RESET = 1'b0;

    int checks = 0;
    int errors = 0;

    instr_mem_responder_if #(.MEM_DEPTH(1024)) bus ();

    instr_mem_responder #(
        .MEM_DEPTH(1024),
        .LATENCY  (4)
    ) dut (
        .CLK  (CLK),
        .RESET(RESET),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

`ifdef IMEM_LINEBUF_EN
    localparam int HIT_BUSY = 0;
    localparam logic HELD_BUSY = 1'b0;
`else
    localparam int HIT_BUSY = 4;
    localparam logic HELD_BUSY = 1'b1;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic load_byte(input logic [9:0] a, input logic [7:0] d);
        bus.LOADEN   = 1'b1;
        bus.LOADADDR = a;
        bus.LOADDATA = d;
        tick();
        bus.LOADEN = 1'b0;
    endtask

    // Issue one READ, optionally inject a load during busy cycle ld_at, count busy samples.
    task automatic fetch(input string tag, input logic [31:0] pc, input int exp_busy,
                         input logic [31:0] exp_word, input bit do_ld = 0,
                         input int ld_at = 0, input logic [9:0] ld_a = '0,
                         input logic [7:0] ld_d = '0);
        int n;
        bus.PC   = pc;
        bus.READ = 1'b1;
        tick();
        bus.READ = 1'b0;
        n = 0;
        while (bus.BUSYWAIT && n < 40) begin
            if (do_ld && n == ld_at) begin
                bus.LOADEN   = 1'b1;
                bus.LOADADDR = ld_a;
                bus.LOADDATA = ld_d;
            end
            n++;
            tick();
            bus.LOADEN = 1'b0;
        end
        check({tag, "_busy"}, 32'(n), 32'(exp_busy));
        check({tag, "_word"}, bus.INSTRUCTION, exp_word);
    endtask

    initial begin
        int n;
        bus.PC       = '0;
        bus.READ     = 1'b0;
        bus.LOADEN   = 1'b0;
        bus.LOADADDR = '0;
        bus.LOADDATA = '0;
        #1;

        load_byte(10'd0, 8'h00);
        load_byte(10'd1, 8'h02);
        load_byte(10'd2, 8'h01);
        load_byte(10'd3, 8'h03);
        load_byte(10'd4, 8'h44);
        load_byte(10'd5, 8'h55);
        load_byte(10'd6, 8'h66);
        load_byte(10'd7, 8'h77);
        load_byte(10'd8, 8'h10);
        load_byte(10'd9, 8'h20);
        load_byte(10'd10, 8'h30);
        load_byte(10'd11, 8'h40);
        load_byte(10'd16, 8'hAA);
        load_byte(10'd17, 8'hBB);
        load_byte(10'd18, 8'hCC);
        load_byte(10'd19, 8'hDD);

        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        check("rst_busy", 32'(bus.BUSYWAIT), 32'd0);
        check("rst_instr", bus.INSTRUCTION, 32'h0);

        fetch("pc0", 32'h0, 4, 32'h03010200);
        fetch("pc4", 32'h4, HIT_BUSY, 32'h77665544);
        fetch("pc16", 32'h10, 4, 32'hDDCCBBAA);
        fetch("wrap", 32'h402, 4, 32'h03010200);

        load_byte(10'd8, 8'h99);
        fetch("pc8_reload", 32'h8, 4, 32'h40302099);

        repeat (3) tick();
        check("hold_instr", bus.INSTRUCTION, 32'h40302099);
        check("hold_busy", 32'(bus.BUSYWAIT), 32'd0);

        load_byte(10'd2, 8'h01);
        fetch("ld_wait", 32'h0, 4, 32'h0301FF00, 1'b1, 1, 10'd1, 8'hFF);

        bus.PC   = 32'h10;
        bus.READ = 1'b1;
        tick();
        bus.READ = 1'b0;
        tick();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        check("abort_busy", 32'(bus.BUSYWAIT), 32'd0);
        check("abort_instr", bus.INSTRUCTION, 32'h0);
        repeat (6) tick();
        check("abort_late", bus.INSTRUCTION, 32'h0);

        fetch("mem_kept", 32'h0, 4, 32'h0301FF00);

        bus.PC   = 32'h10;
        bus.READ = 1'b1;
        tick();
        n = 0;
        while (bus.BUSYWAIT && n < 40) begin
            n++;
            tick();
        end
        check("held_busy_cnt", 32'(n), 32'd4);
        check("held_word", bus.INSTRUCTION, 32'hDDCCBBAA);
        tick();
        check("held_restart", 32'(bus.BUSYWAIT), 32'(HELD_BUSY));
        bus.READ = 1'b0;
        n = 0;
        while (bus.BUSYWAIT && n < 40) begin
            n++;
            tick();
        end
        check("held_drain", 32'(bus.BUSYWAIT), 32'd0);
        check("held_word2", bus.INSTRUCTION, 32'hDDCCBBAA);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/instr_mem_responder.md
INSTR_MEM_RESPONDER -- requirements
Module: instr_mem_responder

Interface
REQ-001 Parameter MEM_DEPTH, default 1024, SHALL give the instruction store size in bytes (power of two).
REQ-002 Parameter LATENCY, default 4, SHALL give the miss access time in CLK cycles (range 1..15).
REQ-003 CLK  input  1  SHALL be the clock; all state changes on its rising edge.
REQ-004 RESET  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 PC  input  32  SHALL be the fetch address from the CPU.
REQ-006 READ  input  1  SHALL be the fetch request strobe.
REQ-007 LOADEN  input  1  SHALL be the byte-load strobe for program preload.
REQ-008 LOADADDR  input  log2(MEM_DEPTH)  SHALL be the byte address for the load.
REQ-009 LOADDATA  input  8  SHALL be the byte to store.
REQ-010 INSTRUCTION  output  32  SHALL be the registered fetched word.
REQ-011 BUSYWAIT  output  1  SHALL be a registered flag: high while a fetch is in progress.

Function
REQ-012 Address SHALL be word-aligned: PC[1:0] ignored; byte index a = {PC[log2(MEM_DEPTH)-1:2], 2'b00}; higher PC bits ignored (wrap modulo MEM_DEPTH).
REQ-013 Word assembly SHALL be little-endian: INSTRUCTION[7:0]=mem[a], [15:8]=mem[a+1], [23:16]=mem[a+2], [31:24]=mem[a+3].
REQ-014 FSM states SHALL be IDLE and WAIT; at an edge in IDLE with READ=1 and a miss, latch a, load counter with LATENCY-1, set BUSYWAIT=1, go to WAIT.
REQ-015 In WAIT, each edge SHALL decrement the counter; at the edge where the counter equals 0, INSTRUCTION SHALL load the word at latched a, BUSYWAIT SHALL clear, state SHALL return to IDLE.
REQ-016 BUSYWAIT SHALL therefore be high for exactly LATENCY consecutive cycles per miss; LATENCY=1 SHALL give one busy cycle.
REQ-017 READ and PC changes SHALL be ignored while in WAIT; the latched address SHALL be used.
REQ-018 INSTRUCTION SHALL hold its last value whenever no fetch completes on an edge.
REQ-019 At an edge with LOADEN=1, mem[LOADADDR] SHALL take LOADDATA, in any FSM state.
REQ-020 Memory read for a completing fetch SHALL sample contents before that edge's load; a load to the fetched word at an earlier WAIT edge SHALL be visible in the returned word.
REQ-021 Simultaneous READ and LOADEN in IDLE SHALL both take effect; the fetch sees pre-load contents if it hits, and the completion-edge contents if it misses.
REQ-022 READ held high after completion SHALL start a new fetch at the next edge in IDLE.

Reset
REQ-023 At an edge with RESET=1: state IDLE, counter 0, BUSYWAIT 0, INSTRUCTION 32'h00000000, line buffer invalid; RESET SHALL take priority over READ and LOADEN.
REQ-024 Reset during WAIT SHALL abort the fetch with no INSTRUCTION update.
REQ-025 Memory contents SHALL NOT be cleared by reset.

Configuration
REQ-026 Macro IMEM_LINEBUF_EN defined SHALL add a one-line buffer: 16-byte block, tag = PC[log2(MEM_DEPTH)-1:4], valid bit.
REQ-027 With IMEM_LINEBUF_EN, a READ in IDLE with valid and tag match (hit) SHALL load INSTRUCTION at that same edge from the buffer, BUSYWAIT stays 0, state stays IDLE.
REQ-028 With IMEM_LINEBUF_EN, a miss SHALL take LATENCY cycles per REQ-015, filling all 16 bytes of the block and setting valid and tag at the completion edge.
REQ-029 With IMEM_LINEBUF_EN, a load whose LOADADDR falls in the buffered block SHALL clear valid at that edge.
REQ-030 Without IMEM_LINEBUF_EN, every READ SHALL be a miss; no buffer storage SHALL exist.

Verification
REQ-031 Preload bytes 00 02 01 03 at addresses 0..3, RESET one cycle, READ=1 with PC=0 -> BUSYWAIT high 4 cycles, then INSTRUCTION=32'h03010200, BUSYWAIT=0.
REQ-032 PC=32'h00000402 with MEM_DEPTH=1024 -> word from byte index 0 returned (wrap and alignment).
REQ-033 RESET asserted in second WAIT cycle -> BUSYWAIT=0 next cycle, INSTRUCTION=0, no later update.
REQ-034 LOADEN to address 1 with data 8'hFF during WAIT cycle 2 of fetch PC=0 -> INSTRUCTION=32'h0301FF00.
REQ-035 IMEM_LINEBUF_EN: fetch PC=0 (4 busy cycles), then PC=4 -> INSTRUCTION at the request edge, BUSYWAIT never high; PC=16 -> 4 busy cycles.
REQ-036 IMEM_LINEBUF_EN: after buffering block 0, load address 8, fetch PC=8 -> miss, 4 busy cycles, new byte returned.
